filter_fade_sel: RTL and testbench

- Parametrised successor to the fixed five-way filter selector in the video filter path.
- Selects one of NUM_FILTERS filter outputs from button input.
- On a filter change, crossfades from the old filter's output to the new one over 2^FADE_SHIFT video frames instead of switching hard.
- Sits between the filter instances and the display/passport compositing stage; output is registered, with 1-cycle latency.

---
 rtl/filter_fade_sel.sv | 150 +++++++++++++++
 tb/tb_filter_fade_sel.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_fade_sel.sv
// Filter output selector for the video path: picks one of NUM_FILTERS pixel
// streams from button input and crossfades between filters over 2^FADE_SHIFT frames.
module filter_fade_sel #(
  parameter int NUM_FILTERS = 5,
  parameter int SEL_W       = 3,
  parameter int DEFAULT_SEL = 0,
  parameter int CH_W        = 8,
  parameter int FADE_SHIFT  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            filters_en,
  input  logic                            user_in_en,
  input  logic [NUM_FILTERS-1:0]          sel_in,
  input  logic [10:0]                     hcount,
  input  logic [9:0]                      vcount,
  input  logic [3*CH_W-1:0]               rgb_in,
  input  logic [NUM_FILTERS*3*CH_W-1:0]   rgb_filt,
  output logic [3*CH_W-1:0]               rgb_out,
  output logic [SEL_W-1:0]                filter,
  output logic                            fading,
  output logic                            state_dbg
);

  localparam int PW = 3 * CH_W;
  localparam int AW = (FADE_SHIFT > 0) ? FADE_SHIFT : 1;
  localparam int MW = CH_W + FADE_SHIFT + 1;
  localparam int S  = 1 << FADE_SHIFT;

  localparam logic [SEL_W-1:0]    DEF_SEL    = SEL_W'(DEFAULT_SEL);
  localparam logic [AW-1:0]       ALPHA_LAST = AW'(S - 1);
  localparam logic [FADE_SHIFT:0] S_VAL      = (FADE_SHIFT + 1)'(S);

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  target, target_nxt;
  logic [SEL_W-1:0]  prev, prev_nxt;
  logic [AW-1:0]     alpha, alpha_nxt;
  logic              frame_start, frame_start_q, tick;
  logic              req_vld;
  logic [SEL_W-1:0]  req;
  logic [PW-1:0]     tgt_pix, prev_pix, rgb_nxt;

  // Edge-detect the frame origin so a stalled raster at (0,0) ticks only once.
  assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);
  assign tick        = frame_start && !frame_start_q;

  assign filter    = target;
  assign fading    = (state == FADE);
  assign state_dbg = state;

  // Request decode: all buttons is the reset gesture, otherwise lowest index wins.
  always_comb begin
    req_vld = 1'b0;
    req     = DEF_SEL;
    if (filters_en && user_in_en) begin
      if (&sel_in) begin
        req_vld = 1'b1;
        req     = DEF_SEL;
      end else begin
        for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
          if (sel_in[i]) begin
            req_vld = 1'b1;
            req     = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    tgt_pix  = '0;
    prev_pix = '0;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      if (target == SEL_W'(i)) tgt_pix  = rgb_filt[i*PW +: PW];
      if (prev   == SEL_W'(i)) prev_pix = rgb_filt[i*PW +: PW];
    end
  end

  // Weighted blend of one channel; the sum never exceeds (2^CH_W-1)*S.
  function automatic logic [CH_W-1:0] mix_ch(input logic [CH_W-1:0] p,
                                             input logic [CH_W-1:0] t,
                                             input logic [AW-1:0]   a);
    logic [MW-1:0] wp, wt, sum;
    wp  = MW'(S_VAL - (FADE_SHIFT + 1)'(a));
    wt  = MW'(a);
    sum = MW'(p) * wp + MW'(t) * wt;
    return CH_W'(sum >> FADE_SHIFT);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      target        <= DEF_SEL;
      prev          <= DEF_SEL;
      alpha         <= '0;
      frame_start_q <= 1'b0;
      rgb_out       <= '0;
    end else begin
      state         <= state_nxt;
      target        <= target_nxt;
      prev          <= prev_nxt;
      alpha         <= alpha_nxt;
      frame_start_q <= frame_start;
      rgb_out       <= rgb_nxt;
    end
  end

  // Bypass beats requests, and an accepted request beats a same-cycle tick.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    prev_nxt   = prev;
    alpha_nxt  = alpha;
    if (!filters_en) begin
      state_nxt = IDLE;
      alpha_nxt = '0;
      prev_nxt  = target;
    end else if (req_vld && (req != target)) begin
      prev_nxt   = target;
      target_nxt = req;
      alpha_nxt  = '0;
      state_nxt  = (FADE_SHIFT == 0) ? IDLE : FADE;
    end else if ((state == FADE) && tick) begin
      if (alpha == ALPHA_LAST) begin
        state_nxt = IDLE;
        alpha_nxt = '0;
      end else begin
        alpha_nxt = alpha + AW'(1);
      end
    end
  end

  always_comb begin
    rgb_nxt = tgt_pix;
    if (!filters_en) begin
      rgb_nxt = rgb_in;
    end else if (state == FADE) begin
      for (int c = 0; c < 3; c++) begin
        rgb_nxt[c*CH_W +: CH_W] = mix_ch(prev_pix[c*CH_W +: CH_W],
                                         tgt_pix[c*CH_W +: CH_W], alpha);
      end
    end
  end

endmodule

// File: tb/tb_filter_fade_sel.sv
// Directed bench for filter_fade_sel: a vector table for steady-state muxing plus
// hand-written sequences for fades, retargets, bypass and tick edges.
module tb_filter_fade_sel;

  localparam int NF = 5;
  localparam int PW = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              filters_en;
  logic              user_in_en;
  logic [NF-1:0]     sel_in;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic [PW-1:0]     rgb_in;
  logic [PW-1:0]     filt [NF];
  logic [NF*PW-1:0]  rgb_filt;

  logic [PW-1:0]     rgb_out, rgb_out0;
  logic [2:0]        filter, filter0;
  logic              fading, fading0;
  logic              state_dbg, state_dbg0;

  int errors = 0;
  int checks = 0;
  int fade0_cnt = 0;
  logic [PW-1:0] exp_q[$];

  typedef struct {
    logic          en;
    logic [PW-1:0] rin;
    logic [PW-1:0] f0;
    logic [PW-1:0] exp;
  } vec_t;
  vec_t tbl[6];

  always_comb begin
    rgb_filt = '0;
    for (int i = 0; i < NF; i++) rgb_filt[i*PW +: PW] = filt[i];
  end

  // clock / reset
  always #5 clk = ~clk;

  filter_fade_sel dut (
    .clk(clk), .rst(rst), .filters_en(filters_en), .user_in_en(user_in_en),
    .sel_in(sel_in), .hcount(hcount), .vcount(vcount), .rgb_in(rgb_in),
    .rgb_filt(rgb_filt), .rgb_out(rgb_out), .filter(filter), .fading(fading),
    .state_dbg(state_dbg)
  );

  filter_fade_sel #(.FADE_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .filters_en(filters_en), .user_in_en(user_in_en),
    .sel_in(sel_in), .hcount(hcount), .vcount(vcount), .rgb_in(rgb_in),
    .rgb_filt(rgb_filt), .rgb_out(rgb_out0), .filter(filter0), .fading(fading0),
    .state_dbg(state_dbg0)
  );

  always @(negedge clk) if (!rst && fading0) fade0_cnt++;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [NF-1:0] s);
    sel_in = s;
    step();
    sel_in = '0;
    step();
  endtask

  task automatic frame_tick();
    hcount = 11'd0;
    vcount = 10'd0;
    step();
    hcount = 11'd5;
    vcount = 10'd5;
    step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int changes;
    logic [2:0] last;

    rst = 1'b1; filters_en = 1'b1; user_in_en = 1'b1; sel_in = '0;
    hcount = 11'd5; vcount = 10'd5; rgb_in = '0;
    for (int i = 0; i < NF; i++) filt[i] = '0;
    step();
    step();
    check("reset_rgb_out", rgb_out, 24'h0);
    check("reset_filter", filter, 3'd0);
    check("reset_fading", fading, 1'b0);
    check("reset_state", state_dbg, 1'b0);
    rst = 1'b0;
    filt[0] = 24'h404040;
    step();
    check("idle_latency", rgb_out, 24'h404040);

    tbl[0] = '{1'b1, 24'h111111, 24'h404040, 24'h404040};
    tbl[1] = '{1'b0, 24'hA5A5A5, 24'h404040, 24'hA5A5A5};
    tbl[2] = '{1'b1, 24'hA5A5A5, 24'h00FF00, 24'h00FF00};
    tbl[3] = '{1'b0, 24'h123456, 24'h00FF00, 24'h123456};
    tbl[4] = '{1'b1, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
    tbl[5] = '{1'b1, 24'hFFFFFF, 24'h000000, 24'h000000};
    for (int i = 0; i < 6; i++) begin
      filters_en = tbl[i].en;
      rgb_in     = tbl[i].rin;
      filt[0]    = tbl[i].f0;
      exp_q.push_back(tbl[i].exp);
      step();
      check("table_rgb_out", rgb_out, exp_q.pop_front());
      check("table_filter", filter, 3'd0);
    end
    filters_en = 1'b1;

    // crossfade 0 -> 1
    filt[0] = 24'h000000; filt[1] = 24'hF0F0F0; filt[2] = 24'h101010;
    filt[3] = 24'h303030; filt[4] = 24'h505050;
    press(5'b00010);
    check("fade_filter", filter, 3'd1);
    check("fade_fading", fading, 1'b1);
    check("fade_alpha0", rgb_out, 24'h000000);
    frame_tick();
    check("fade_alpha1", rgb_out, 24'h0F0F0F);
    for (int i = 0; i < 7; i++) frame_tick();
    check("fade_alpha8", rgb_out, 24'h787878);
    for (int i = 0; i < 7; i++) frame_tick();
    check("fade_alpha15", rgb_out, 24'hE1E1E1);
    check("fade_alpha15_fading", fading, 1'b1);
    frame_tick();
    check("fade_done_fading", fading, 1'b0);
    check("fade_done_rgb", rgb_out, 24'hF0F0F0);

    // gesture and priority
    press(5'b01000);
    check("sel3_filter", filter, 3'd3);
    press(5'b11111);
    check("gesture_filter", filter, 3'd0);
    check("gesture_fading", fading, 1'b1);
    press(5'b01100);
    check("priority_filter", filter, 3'd2);
    press(5'b00001);
    sel_in = 5'b00100;
    changes = 0;
    last = filter;
    for (int i = 0; i < 100; i++) begin
      step();
      if (filter !== last) changes++;
      last = filter;
    end
    sel_in = '0;
    check("hold_one_change", changes, 1);
    check("hold_filter", filter, 3'd2);

    // mid-fade retarget
    filters_en = 1'b0; step(); filters_en = 1'b1;
    press(5'b00001);
    filters_en = 1'b0; step(); filters_en = 1'b1;
    press(5'b00010);
    for (int i = 0; i < 5; i++) frame_tick();
    check("retarget_alpha5", rgb_out, 24'h4B4B4B);
    press(5'b00100);
    check("retarget_prev1", rgb_out, 24'hF0F0F0);
    check("retarget_filter", filter, 3'd2);
    frame_tick();
    check("retarget_alpha1", rgb_out, 24'hE2E2E2);
    hcount = 11'd0; vcount = 10'd0; sel_in = 5'b00010;
    step();
    hcount = 11'd5; vcount = 10'd5; sel_in = '0;
    step();
    check("req_beats_tick", rgb_out, 24'h101010);
    check("req_beats_tick_filter", filter, 3'd1);

    // bypass mid-fade
    filters_en = 1'b0; rgb_in = 24'hABCDEF; sel_in = 5'b00001;
    step();
    check("bypass_rgb", rgb_out, 24'hABCDEF);
    check("bypass_fading", fading, 1'b0);
    rgb_in = 24'h123456;
    step();
    check("bypass_rgb2", rgb_out, 24'h123456);
    check("bypass_sel_ignored", filter, 3'd1);
    filters_en = 1'b1; sel_in = '0;
    step();
    check("reenable_rgb", rgb_out, 24'hF0F0F0);
    check("reenable_fading", fading, 1'b0);

    // stalled raster at (0,0) ticks once
    press(5'b00001);
    hcount = 11'd0; vcount = 10'd0;
    for (int i = 0; i < 10; i++) step();
    hcount = 11'd5; vcount = 10'd5;
    step();
    check("stall_one_tick", rgb_out, 24'hE1E1E1);
    check("stall_fading", fading, 1'b1);

    // hard switch instance
    press(5'b00100);
    check("hard_filter", filter0, 3'd2);
    check("hard_fading", fading0, 1'b0);
    check("hard_rgb", rgb_out0, 24'h101010);

    // reset mid-fade
    filt[0] = 24'h404040;
    rst = 1'b1;
    step();
    check("rst_mid_rgb", rgb_out, 24'h0);
    check("rst_mid_filter", filter, 3'd0);
    check("rst_mid_fading", fading, 1'b0);
    rst = 1'b0;
    step();
    check("rst_mid_after_rgb", rgb_out, 24'h404040);
    check("rst_mid_after_fading", fading, 1'b0);
    check("hard_never_fading", fade0_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
